ram_port_arbiter: RTL

- Shares port A of the 16-bit x 1K dual-port RAM between two masters.
- Master 0 is the CPU load/store unit; master 1 is the I/O/DMA engine.
- Round-robin arbitration, one access per cycle, req/gnt handshake, tagged read-data return matched to the RAM's registered read latency.
- Port B stays dedicated to instruction fetch and is outside this block.

---
 rtl/ram_pkg.sv | 18 +
 rtl/ram_port_arbiter_if.sv | 43 ++++
 rtl/rr_arbiter2.sv | 37 +++
 rtl/ram_port_arbiter.sv | 78 +++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the port-A arbiter of the 16-bit x 1K dual-port RAM.
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default word and address widths
//   MASTER_CPU / MASTER_IO          : master indices (load/store unit, I/O-DMA engine)
//   rd_tag_t                        : read-return tag carried down the latency pipeline
package ram_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 10;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_IO  = 1'b1;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and RAM port A.
//   mX_req/we/addr/wdata : master X access request, held until mX_gnt
//   mX_gnt               : access accepted this cycle
//   mX_rvalid/rdata      : read return, rdata qualified by rvalid
//   ram_addr/data/we     : drive to RAM addr_a/data_a/we_a
//   ram_q                : RAM q_a_out
// slave  : arbiter side.  master : masters plus RAM side.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);

  logic                  m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata;

  logic                  m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata, m1_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data, ram_q;
  logic                  ram_we;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  ram_q,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_addr, ram_data, ram_we
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output ram_q,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_addr, ram_data, ram_we
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, reset : system clock, synchronous active-high reset
//   req[1:0]   : request per master
//   gnt[1:0]   : one-hot combinational grant, zero during reset
// `last` holds the index of the most recently granted master; on contention
// the other master wins, which bounds the wait of a held request to 2 cycles.
module rr_arbiter2
  import ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == MASTER_IO) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Reset to MASTER_IO so the CPU wins the first contention.
  always_ff @(posedge clk) begin
    if (reset)                 last <= MASTER_IO;
    else if (gnt[MASTER_CPU])  last <= MASTER_CPU;
    else if (gnt[MASTER_IO])   last <= MASTER_IO;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between the CPU load/store unit (master 0) and the
// I/O-DMA engine (master 1): one access per cycle, round-robin grant,
// tagged read return aligned to the RAM's registered read latency.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : ram_port_arbiter_if slave modport (masters and RAM port A)
// Parameters: DATA_WIDTH, ADDR_WIDTH, READ_LATENCY (1..4).
module ram_port_arbiter
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int READ_LATENCY = 1
) (
  input logic                clk,
  input logic                reset,
  ram_port_arbiter_if.slave  bus
);

  logic [1:0]            gnt;
  logic                  gnt_any;
  logic                  sel_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  rd_tag_t               tag_in;
  rd_tag_t               tag_out;
  rd_tag_t               tag_q [READ_LATENCY];

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.m1_req, bus.m0_req}),
    .gnt   (gnt)
  );

  assign gnt_any    = |gnt;
  assign bus.m0_gnt = gnt[MASTER_CPU];
  assign bus.m1_gnt = gnt[MASTER_IO];

  // With no grant the mux rests on master 0; ram_we is what keeps that harmless.
  always_comb begin
    sel_id   = gnt[MASTER_IO];
    sel_we   = bus.m0_we;
    sel_addr = bus.m0_addr;
    sel_data = bus.m0_wdata;
    if (sel_id == MASTER_IO) begin
      sel_we   = bus.m1_we;
      sel_addr = bus.m1_addr;
      sel_data = bus.m1_wdata;
    end
  end

  assign bus.ram_addr = sel_addr;
  assign bus.ram_data = sel_data;
  assign bus.ram_we   = gnt_any & sel_we;

  // Tag travels alongside the RAM's read pipeline so rvalid lines up with q_a.
  assign tag_in.valid = gnt_any & ~sel_we;
  assign tag_in.id    = sel_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[READ_LATENCY-1];

  // Gated by reset so a read in flight when reset rises never reports.
  assign bus.m0_rvalid = ~reset & tag_out.valid & (tag_out.id == MASTER_CPU);
  assign bus.m1_rvalid = ~reset & tag_out.valid & (tag_out.id == MASTER_IO);
  assign bus.m0_rdata  = bus.ram_q;
  assign bus.m1_rdata  = bus.ram_q;

endmodule
